// File: rtl/io_timer_irq.sv
// Memory-mapped prescaled 32-bit timer with compare match and a sticky pending interrupt.
// Write-only registers are decoded from the core's IO store port.
module io_timer_irq #(
   parameter logic [9:0] ADR_BASE = 10'h3F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  st_adr_io,
   input  logic [31:0] st_data_io,
   input  logic [3:0]  st_we_io,
   output logic        interrupt_0,
   output logic        timer_pending,
   output logic [31:0] timer_count
);

   logic [9:0]  offset;
   logic        hit;
   logic        wr_ctrl, wr_presc, wr_cmp, wr_cnt, clr_req;
   logic        en, reload, ie;
   logic [15:0] prescale, presc_cnt;
   logic [31:0] compare, count;
   logic        pending;
   logic        tick, cmp_eq, match;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  we);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++)
         if (we[b]) res[8*b +: 8] = new_val[8*b +: 8];
      return res;
   endfunction

   // Subtracting the base makes out-of-map addresses (including wrap-around) fall outside 0..4.
   assign offset   = st_adr_io - ADR_BASE;
   assign hit      = (st_we_io != 4'b0000) && (offset < 10'd5);
   assign wr_ctrl  = hit && (offset == 10'd0) && st_we_io[0];
   assign wr_presc = hit && (offset == 10'd1);
   assign wr_cmp   = hit && (offset == 10'd2);
   assign clr_req  = hit && (offset == 10'd3) && st_we_io[0] && st_data_io[0];
   assign wr_cnt   = hit && (offset == 10'd4);

   // >= keeps a PRESCALE lowered below presc_cnt from waiting for a 16-bit wrap.
   assign tick   = en && (presc_cnt >= prescale);
   assign cmp_eq = (count == compare);
   assign match  = tick && !wr_cnt && cmp_eq;

   always_ff @(posedge clk) begin
      if (rst) begin
         en          <= 1'b0;
         reload      <= 1'b0;
         ie          <= 1'b0;
         prescale    <= 16'h0000;
         presc_cnt   <= 16'h0000;
         compare     <= 32'hFFFF_FFFF;
         count       <= 32'h0000_0000;
         pending     <= 1'b0;
         interrupt_0 <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en     <= st_data_io[0];
            reload <= st_data_io[1];
            ie     <= st_data_io[2];
         end else if (match && !reload) begin
            en <= 1'b0;
         end

         if (wr_ctrl && st_data_io[0] && !en)
            presc_cnt <= 16'h0000;
         else if (tick)
            presc_cnt <= 16'h0000;
         else if (en)
            presc_cnt <= presc_cnt + 16'd1;

         if (wr_presc && st_we_io[0]) prescale[7:0]  <= st_data_io[7:0];
         if (wr_presc && st_we_io[1]) prescale[15:8] <= st_data_io[15:8];

         if (wr_cmp)
            compare <= merge_bytes(compare, st_data_io, st_we_io);

         if (wr_cnt)
            count <= merge_bytes(count, st_data_io, st_we_io);
         else if (tick) begin
            if (cmp_eq) begin
               if (reload) count <= 32'h0000_0000;
            end else begin
               count <= count + 32'd1;
            end
         end

         if (match)
            pending <= 1'b1;
         else if (clr_req)
            pending <= 1'b0;

         interrupt_0 <= pending && ie;
      end
   end

   assign timer_pending = pending;
   assign timer_count   = count;

endmodule

// File: doc/io_timer_irq.md
# io_timer_irq

Memory-mapped timer peripheral that sits directly downstream of the CPU core's store-to-IO path. It decodes the core's IO store outputs (`st_adr_io`, `st_data_io`, `st_we_io`) into write-only control registers, runs a prescaled 32-bit up-counter with a compare match, and drives the core's `interrupt_0` input with a sticky, software-cleared pending flag. It gives firmware a periodic or one-shot timer interrupt without adding a read path to the core.

## Interface
- `ADR_BASE`, default 10'h3F0: word address (`st_adr_io[11:2]`) of register 0. Registers 0–4 occupy `ADR_BASE` to `ADR_BASE+4`.
- `clk`  input  1  system clock, the same clock as the CPU core.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `st_adr_io`  input  10  word address of the IO store, bits [11:2].
- `st_data_io`  input  32  IO store data.
- `st_we_io`  input  4  per-byte write enables, bit n covers data[8n+7:8n]. All zero means no store.
- `interrupt_0`  output  1  timer interrupt to the core; level, registered.
- `timer_pending`  output  1  raw pending flag, for debug.
- `timer_count`  output  32  current counter value, for debug.

## Operation
- Register map (offset from `ADR_BASE`):
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE. Other bits are ignored.
  - 1 PRESCALE: bits [15:0]. Upper bits are ignored.
  - 2 COMPARE: 32 bits.
  - 3 CLEAR: writing 1 to bit0 clears pending. Writing 0 has no effect.
  - 4 COUNT: 32 bits. Loads the counter.
- Register writes:
  - Each byte is written only when its `st_we_io` bit is set.
  - A store to any word address outside the map is ignored.
  - CLEAR acts only if byte 0 is enabled.
- Prescaler:
  - `presc_cnt` is 16 bits.
  - While EN=1: if `presc_cnt == PRESCALE`, `tick=1` and `presc_cnt` returns to 0; otherwise `presc_cnt` increments.
  - While EN=0: `presc_cnt` holds and `tick=0`.
- Counter on each tick:
  - If `count == COMPARE`, this is a match. Pending is set to 1. If RELOAD=1, count becomes 0. If RELOAD=0, count holds and EN clears to 0 (one-shot).
  - Otherwise count increments, wrapping mod 2^32.
- `interrupt_0 = pending & IE`, registered.
- Simultaneous events:
  - A match and a CLEAR write in the same cycle: set wins, so pending=1.
  - A COUNT write and a tick in the same cycle: the write wins and no match is evaluated that cycle.
  - A COMPARE write and a match in the same cycle: the match uses the old COMPARE value.
  - A CTRL write and a one-shot EN auto-clear in the same cycle: the CTRL write wins.
  - A CTRL write that sets EN from 0 to 1 also resets `presc_cnt` to 0. Writing EN=1 while EN is already 1 does not disturb `presc_cnt`.
- Changing PRESCALE below the current `presc_cnt` causes no wrap-around hazard. Compare with `>=` (`presc_cnt >= PRESCALE` produces a tick).
- Reset mid-count: every register returns to its reset value. No interrupt is produced after reset until it is reprogrammed.

## Timing
- Reset values: CTRL=0, PRESCALE=0, COMPARE=32'hFFFF_FFFF, count=0, `presc_cnt`=0, pending=0, `interrupt_0`=0. Therefore `timer_count`=0 and `timer_pending`=0.
- Register writes take effect on the clock edge of the store cycle, with no backpressure: one store per cycle, always accepted.
- Tick period is PRESCALE+1 cycles.
- Match-to-pending latency: pending is set on the edge ending the match-tick cycle. `interrupt_0` follows one cycle later.
- CLEAR-to-deassert latency: pending drops on the CLEAR edge, and `interrupt_0` drops one cycle later.
- The RELOAD interval between matches is (COMPARE+1)·(PRESCALE+1) cycles.

## Test plan
- Periodic, fast:
  - Stimulus: PRESCALE=0, COMPARE=3, COUNT=0, then CTRL=7.
  - Required: `timer_count` steps 1, 2, 3, 0 on successive edges. pending rises on the 4th edge after the CTRL write, and `interrupt_0` rises on the 5th. The counter matches again every 4 cycles.
- Prescaled one-shot:
  - Stimulus: PRESCALE=2, COMPARE=2, CTRL=5 (no RELOAD).
  - Required: pending rises 9 cycles after enable, then EN reads 0 and count holds at 2. Writing CLEAR=1 drops `interrupt_0` 2 cycles after the store.
- Masking and byte enables:
  - Stimulus 1: IE=0 with a match.
  - Required 1: pending=1 and `interrupt_0`=0. Writing CTRL with IE=1 raises `interrupt_0` one cycle later.
  - Stimulus 2: COMPARE write of 32'h12345678 with `st_we_io`=4'b0010.
  - Required 2: only byte 1 changes, so COMPARE becomes 32'hFFFF56FF.
- Collisions:
  - Stimulus 1: CLEAR issued in the same cycle as a match.
  - Required 1: pending stays 1.
  - Stimulus 2: COUNT=10 written in the same cycle as a tick.
  - Required 2: `timer_count`=10 next cycle.
- Address decode:
  - Stimulus: a store to `ADR_BASE+5`, then a store to 10'h000.
  - Required: no register changes.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle with pending=1 and count=2.
  - Required: all outputs are 0 on the next cycle, and there is no further interrupt without reprogramming.
